// File: rtl/nz_detect_filter.sv
// Per-channel nonzero detector. A channel qualifies after FILTER consecutive nonzero valid samples.
// It also keeps a sticky qualified flag per channel and a saturating count of cycles with any channel qualified.
module nz_detect_filter #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int FILTER   = 3,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      clear,
  output logic [CHANNELS-1:0]       nz_raw,
  output logic [CHANNELS-1:0]       nz_stable,
  output logic [CHANNELS-1:0]       sticky,
  output logic                      any_stable,
  output logic [CNT_W-1:0]          count
);

  localparam int RUN_W = $clog2(FILTER + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CHANNELS-1:0][RUN_W-1:0] r_run;
  logic [CHANNELS-1:0]            r_nz_raw;
  logic [CHANNELS-1:0]            r_sticky;
  logic [CNT_W-1:0]               r_count;
  logic [CHANNELS-1:0]            w_nz;
  logic [CHANNELS-1:0]            w_stable;
  logic                           w_any;

  always_comb begin
    w_nz     = '0;
    w_stable = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_nz[i]     = |data_in[i*WIDTH +: WIDTH];
      w_stable[i] = (r_run[i] == RUN_MAX);
    end
    w_any = |w_stable;
  end

  // Invalid cycles hold run, so gaps in valid_in neither qualify nor break a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run    <= '0;
      r_nz_raw <= '0;
    end else if (valid_in) begin
      r_nz_raw <= w_nz;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_nz[i]) begin
          r_run[i] <= '0;
        end else if (r_run[i] != RUN_MAX) begin
          r_run[i] <= r_run[i] + RUN_W'(1);
        end else begin
          r_run[i] <= r_run[i];
        end
      end
    end else begin
      r_run    <= r_run;
      r_nz_raw <= r_nz_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else begin
      r_sticky <= r_sticky | w_stable;
      if (w_any && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign nz_raw     = r_nz_raw;
  assign nz_stable  = w_stable;
  assign sticky     = r_sticky;
  assign any_stable = w_any;
  assign count      = r_count;

endmodule
